// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer for interlocks, redirect flushes, mem-wait freezes and forwarding.
module hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_werf,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_werf,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_werf,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);
  localparam int TW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_e;
  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, wait_q, wait_d;
  logic             mem_hold, load_use, err, run, do_redir, do_stall;

  function automatic logic [1:0] fwd(input logic [4:0] src);
    return (src == 5'd0) ? 2'b00 :
           (mem_werf && mem_rd == src) ? 2'b01 :
           (wb_werf && wb_rd == src) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction

  assign mem_hold = mem_req & ~mem_ready;
  assign load_use = ex_load & ex_werf & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign err      = (state_q == ERR);
  assign run      = ~rst & ~err & ~mem_hold;
  assign do_redir = run & ex_redirect;
  assign do_stall = run & ~ex_redirect & load_use;

  assign pc_en       = run & ~do_stall;
  assign if_id_en    = run & ~do_stall;
  assign if_id_flush = rst | do_redir;
  assign id_ex_en    = run;
  assign id_ex_flush = rst | do_redir | do_stall;
  assign ex_mem_en   = run;
  assign mem_wb_en   = run;
  assign fwd_a_sel   = rst ? 2'b00 : fwd(ex_rs1);
  assign fwd_b_sel   = rst ? 2'b00 : fwd(ex_rs2);
  assign timeout_err = err;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign wait_cnt    = wait_q;

  // timer counts consecutive hold cycles, including the one that leaves RUN
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == RUN && mem_hold) begin
      timer_d = TW'(1);
      state_d = (WAIT_MAX == 1) ? ERR : WAIT;
    end else if (state_q == WAIT) begin
      timer_d = mem_hold ? timer_q + 1'b1 : timer_q;
      state_d = !mem_hold ? RUN : (timer_d == TW'(WAIT_MAX)) ? ERR : WAIT;
    end
    stall_d = sat_inc(stall_q, do_stall);
    flush_d = sat_inc(flush_q, do_redir);
    wait_d  = sat_inc(wait_q, mem_hold & ~err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      timer_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + random stimulus scored against a behavioural model through an expectation queue.
module tb_hazard_ctrl;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_werf, ex_load, ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_werf, mem_req, mem_ready;
    logic [4:0] wb_rd;
    logic       wb_werf;
  } in_t;

  typedef struct packed {
    logic        chk_reg;
    logic [6:0]  ctl;
    logic [1:0]  fa, fb;
    logic        to;
    logic [31:0] sc, fc, wc;
  } exp_t;

  logic clk = 0;
  in_t  x;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, timeout_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(x.rst),
    .id_rs1(x.id_rs1), .id_rs2(x.id_rs2), .id_rs1_used(x.id_rs1_used), .id_rs2_used(x.id_rs2_used),
    .ex_rs1(x.ex_rs1), .ex_rs2(x.ex_rs2), .ex_rd(x.ex_rd), .ex_werf(x.ex_werf), .ex_load(x.ex_load),
    .ex_redirect(x.ex_redirect), .mem_rd(x.mem_rd), .mem_werf(x.mem_werf), .mem_req(x.mem_req),
    .mem_ready(x.mem_ready), .wb_rd(x.wb_rd), .wb_werf(x.wb_werf),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0, bad = 0;
  bit m_err = 0, m_known = 0;
  int m_wlen = 0, m_sc = 0, m_fc = 0, m_wc = 0;

  function automatic logic [1:0] fw(input in_t i, input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (i.mem_werf && i.mem_rd == src) return 2'b01;
    if (i.wb_werf && i.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int inc(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  // ctl bit order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
  task automatic apply(input in_t i);
    exp_t e;
    bit hold, lu;
    @(posedge clk);
    #1;
    x = i;
    hold = i.mem_req && !i.mem_ready;
    lu = i.ex_load && i.ex_werf && i.ex_rd != 0 &&
         ((i.id_rs1_used && i.id_rs1 == i.ex_rd) || (i.id_rs2_used && i.id_rs2 == i.ex_rd));
    e.chk_reg = m_known;
    e.to = m_err;
    e.sc = m_sc; e.fc = m_fc; e.wc = m_wc;
    e.fa = i.rst ? 2'b00 : fw(i, i.ex_rs1);
    e.fb = i.rst ? 2'b00 : fw(i, i.ex_rs2);
    if (i.rst) begin
      e.ctl = 7'b0010100;
      m_err = 0; m_wlen = 0; m_sc = 0; m_fc = 0; m_wc = 0; m_known = 1;
    end else if (m_err) begin
      e.ctl = 7'b0000000;
    end else if (hold) begin
      e.ctl = 7'b0000000;
      m_wc = inc(m_wc);
      m_wlen++;
      if (m_wlen == WAIT_MAX) m_err = 1;
    end else begin
      m_wlen = 0;
      if (i.ex_redirect) begin
        e.ctl = 7'b1111111;
        m_fc = inc(m_fc);
      end else if (lu) begin
        e.ctl = 7'b0001111;
        m_sc = inc(m_sc);
      end else e.ctl = 7'b1101011;
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl", {25'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}, {25'd0, e.ctl});
        chk("fwd_a", {30'd0, fwd_a_sel}, {30'd0, e.fa});
        chk("fwd_b", {30'd0, fwd_b_sel}, {30'd0, e.fb});
        if (e.chk_reg) begin
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
          chk("stall_cnt", 32'(stall_cnt), e.sc);
          chk("flush_cnt", 32'(flush_cnt), e.fc);
          chk("wait_cnt", 32'(wait_cnt), e.wc);
        end
      end
    end
  end

  function automatic in_t idle();
    in_t i = '0;
    return i;
  endfunction

  initial begin
    in_t i;
    x = idle();
    x.rst = 1;
    i = idle(); i.rst = 1;
    repeat (2) apply(i);
    apply(idle());
    i = idle(); i.ex_load = 1; i.ex_werf = 1; i.ex_rd = 5;
    i.id_rs1 = 5; i.id_rs1_used = 1; i.id_rs2 = 7; i.id_rs2_used = 1;
    apply(i);
    i = idle(); i.ex_rs1 = 5; i.ex_rs2 = 7; i.wb_rd = 5; i.wb_werf = 1;
    apply(i);
    i = idle(); i.mem_rd = 3; i.mem_werf = 1; i.wb_rd = 3; i.wb_werf = 1; i.ex_rs1 = 3; i.ex_rs2 = 0;
    apply(i);
    i = idle(); i.ex_rs1 = 0; i.mem_rd = 0; i.mem_werf = 1;
    apply(i);
    i = idle(); i.rst = 1;
    apply(i);
    i = idle(); i.ex_redirect = 1; i.ex_load = 1; i.ex_werf = 1; i.ex_rd = 9;
    i.id_rs2 = 9; i.id_rs2_used = 1;
    apply(i);
    i = idle(); i.mem_req = 1;
    repeat (3) apply(i);
    i.mem_ready = 1;
    apply(i);
    apply(idle());
    i = idle(); i.mem_req = 1;
    repeat (6) apply(i);
    i = idle(); i.ex_redirect = 1;
    repeat (2) apply(i);
    i = idle(); i.rst = 1;
    apply(i);
    apply(idle());
    for (int n = 0; n < 2000; n++) begin
      i.rst         = ($urandom_range(0, 99) == 0);
      i.id_rs1      = 5'($urandom_range(0, 3));
      i.id_rs2      = 5'($urandom_range(0, 3));
      i.id_rs1_used = 1'($urandom);
      i.id_rs2_used = 1'($urandom);
      i.ex_rs1      = 5'($urandom_range(0, 3));
      i.ex_rs2      = 5'($urandom_range(0, 3));
      i.ex_rd       = 5'($urandom_range(0, 3));
      i.ex_werf     = 1'($urandom);
      i.ex_load     = 1'($urandom);
      i.ex_redirect = ($urandom_range(0, 3) == 0);
      i.mem_rd      = 5'($urandom_range(0, 3));
      i.mem_werf    = 1'($urandom);
      i.mem_req     = ($urandom_range(0, 2) == 0);
      i.mem_ready   = ($urandom_range(0, 2) == 0);
      i.wb_rd       = 5'($urandom_range(0, 3));
      i.wb_werf     = 1'($urandom);
      apply(i);
    end
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
